// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch and data stages
// One access at a time; a forced RESP cycle keeps the memory port idle between accesses.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  input  logic          FlushF,
  output logic [DW-1:0] irdata,
  output logic          ivalid,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dvalid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          StallF,
  output logic          StallM
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] irdata_q;
  logic [DW-1:0] drdata_q;
  logic          ivalid_q;
  logic          dvalid_q;
  logic          drop_q;
  logic          last_d_q;

  // D wins ties unless D was the last port to complete.
  logic grant_d;
  assign grant_d = dreq && (!ireq || !last_d_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      ivalid_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      drop_q      <= 1'b0;
      last_d_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            mem_addr_q  <= daddr;
            mem_we_q    <= dwe;
            mem_wdata_q <= dwdata;
            mem_req_q   <= 1'b1;
            state_q     <= BUSY_D;
          end else if (ireq) begin
            mem_addr_q <= iaddr;
            mem_we_q   <= 1'b0;
            mem_req_q  <= 1'b1;
            drop_q     <= 1'b0;
            state_q    <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (FlushF) drop_q <= 1'b1;
          if (mem_ready) begin
            irdata_q  <= mem_rdata;
            mem_req_q <= 1'b0;
            last_d_q  <= 1'b0;
            ivalid_q  <= !(drop_q || FlushF);
            state_q   <= RESP;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            drdata_q  <= mem_rdata;
            mem_req_q <= 1'b0;
            last_d_q  <= 1'b1;
            dvalid_q  <= 1'b1;
            state_q   <= RESP;
          end
        end
        default: begin
          ivalid_q <= 1'b0;
          dvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // A flush arriving during the response cycle still kills the fetch pulse.
  assign ivalid    = ivalid_q && !FlushF;
  assign dvalid    = dvalid_q;
  assign irdata    = irdata_q;
  assign drdata    = drdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign StallF    = ireq && !ivalid;
  assign StallM    = dreq && !dvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq;
  logic [31:0] iaddr;
  logic        FlushF;
  logic [31:0] irdata;
  logic        ivalid;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dvalid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        StallF;
  logic        StallM;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .FlushF(FlushF), .irdata(irdata), .ivalid(ivalid),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .dvalid(dvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallF(StallF), .StallM(StallM)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; ireq = 1'b1; dreq = 1'b1; iaddr = 32'h0040_0100; FlushF = 1'b0;
    dwe = 1'b0; daddr = 32'h1001_0040; dwdata = 32'h0; mem_ready = 1'b1; mem_rdata = 32'h1111_2222;

    // reset held with both requests and mem_ready high
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check_eq("rst_ivalid", {31'b0, ivalid}, 32'd0);
      check_eq("rst_dvalid", {31'b0, dvalid}, 32'd0);
      check_eq("rst_irdata", irdata, 32'h0);
      check_eq("rst_drdata", drdata, 32'h0);
    end
    cyc(); reset = 1'b1; mem_ready = 1'b0; #1;
    check_eq("rel_stallm", {31'b0, StallM}, 32'd1);
    cyc(); mem_ready = 1'b1; #1;
    check_eq("first_grant_d_req", {31'b0, mem_req}, 32'd1);
    check_eq("first_grant_d_addr", mem_addr, 32'h1001_0040);
    cyc(); mem_ready = 1'b0; ireq = 1'b0; #1;
    check_eq("first_dvalid", {31'b0, dvalid}, 32'd1);
    check_eq("first_ivalid", {31'b0, ivalid}, 32'd0);
    check_eq("first_drdata", drdata, 32'h1111_2222);
    cyc(); dreq = 1'b0; #1;
    check_eq("first_dvalid_off", {31'b0, dvalid}, 32'd0);
    check_eq("idle_gap_req", {31'b0, mem_req}, 32'd0);

    // single fetch, zero-wait
    cyc(); ireq = 1'b1; iaddr = 32'h0040_0000; #1;
    check_eq("f_c0_stallf", {31'b0, StallF}, 32'd1);
    check_eq("f_c0_req", {31'b0, mem_req}, 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h8C08_0004; #1;
    check_eq("f_c1_req", {31'b0, mem_req}, 32'd1);
    check_eq("f_c1_addr", mem_addr, 32'h0040_0000);
    check_eq("f_c1_we", {31'b0, mem_we}, 32'd0);
    check_eq("f_c1_stallf", {31'b0, StallF}, 32'd1);
    cyc(); mem_ready = 1'b0; #1;
    check_eq("f_c2_ivalid", {31'b0, ivalid}, 32'd1);
    check_eq("f_c2_irdata", irdata, 32'h8C08_0004);
    check_eq("f_c2_stallf", {31'b0, StallF}, 32'd0);
    check_eq("f_c2_req", {31'b0, mem_req}, 32'd0);
    cyc(); ireq = 1'b0; #1;
    check_eq("f_c3_ivalid", {31'b0, ivalid}, 32'd0);

    // store with wait states, mem_ready in cycle 4
    cyc(); dreq = 1'b1; dwe = 1'b1; daddr = 32'h1001_0000; dwdata = 32'hDEAD_BEEF; #1;
    check_eq("s_c0_stallm", {31'b0, StallM}, 32'd1);
    for (int c = 1; c <= 4; c++) begin
      cyc(); mem_ready = (c == 4); mem_rdata = 32'h5555_AAAA; #1;
      check_eq("s_req", {31'b0, mem_req}, 32'd1);
      check_eq("s_we", {31'b0, mem_we}, 32'd1);
      check_eq("s_addr", mem_addr, 32'h1001_0000);
      check_eq("s_wdata", mem_wdata, 32'hDEAD_BEEF);
      check_eq("s_dvalid_early", {31'b0, dvalid}, 32'd0);
      check_eq("s_stallm", {31'b0, StallM}, 32'd1);
    end
    cyc(); mem_ready = 1'b0; #1;
    check_eq("s_c5_dvalid", {31'b0, dvalid}, 32'd1);
    check_eq("s_c5_stallm", {31'b0, StallM}, 32'd0);
    check_eq("s_c5_req", {31'b0, mem_req}, 32'd0);
    cyc(); dreq = 1'b0; dwe = 1'b0; #1;
    check_eq("s_c6_dvalid", {31'b0, dvalid}, 32'd0);

    // one-cycle reset so that D wins the next tie
    cyc(); reset = 1'b0;
    cyc(); reset = 1'b1;

    // contention: D, then I, then D again
    ireq = 1'b1; dreq = 1'b1; iaddr = 32'h0040_0200; daddr = 32'h1001_0200; #1;
    cyc(); mem_ready = 1'b1; mem_rdata = 32'hAAAA_0001; #1;
    check_eq("c_first_addr_d", mem_addr, 32'h1001_0200);
    cyc(); mem_ready = 1'b0; #1;
    check_eq("c_d_dvalid", {31'b0, dvalid}, 32'd1);
    check_eq("c_d_ivalid", {31'b0, ivalid}, 32'd0);
    cyc(); #1;
    check_eq("c_idle_req", {31'b0, mem_req}, 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'hBBBB_0002; #1;
    check_eq("c_second_addr_i", mem_addr, 32'h0040_0200);
    check_eq("c_second_we", {31'b0, mem_we}, 32'd0);
    cyc(); mem_ready = 1'b0; #1;
    check_eq("c_i_ivalid", {31'b0, ivalid}, 32'd1);
    check_eq("c_i_irdata", irdata, 32'hBBBB_0002);
    check_eq("c_drdata_hold", drdata, 32'hAAAA_0001);
    cyc(); ireq = 1'b0; #1;
    cyc(); mem_ready = 1'b1; mem_rdata = 32'hCCCC_0003; #1;
    check_eq("c_third_addr_d", mem_addr, 32'h1001_0200);
    cyc(); mem_ready = 1'b0; #1;
    check_eq("c_third_dvalid", {31'b0, dvalid}, 32'd1);
    cyc(); dreq = 1'b0; #1;

    // flush during BUSY_I
    cyc(); ireq = 1'b1; iaddr = 32'h0040_0010; #1;
    cyc(); #1;
    check_eq("fl_c1_req", {31'b0, mem_req}, 32'd1);
    cyc(); FlushF = 1'b1; #1;
    check_eq("fl_c2_req", {31'b0, mem_req}, 32'd1);
    cyc(); FlushF = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678; #1;
    check_eq("fl_c3_req", {31'b0, mem_req}, 32'd1);
    cyc(); mem_ready = 1'b0; #1;
    check_eq("fl_c4_ivalid", {31'b0, ivalid}, 32'd0);
    check_eq("fl_c4_req", {31'b0, mem_req}, 32'd0);
    check_eq("fl_c4_irdata", irdata, 32'h1234_5678);
    cyc(); ireq = 1'b0; #1;
    check_eq("fl_c5_ivalid", {31'b0, ivalid}, 32'd0);

    // reset in the middle of a data access
    cyc(); dreq = 1'b1; dwe = 1'b0; daddr = 32'h1001_0080; #1;
    cyc(); #1;
    check_eq("rm_c1_req", {31'b0, mem_req}, 32'd1);
    cyc(); reset = 1'b0; #1;
    check_eq("rm_c2_req", {31'b0, mem_req}, 32'd1);
    cyc(); reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h9999_9999; dreq = 1'b0; #1;
    check_eq("rm_c3_req", {31'b0, mem_req}, 32'd0);
    check_eq("rm_c3_dvalid", {31'b0, dvalid}, 32'd0);
    cyc(); mem_ready = 1'b0; #1;
    check_eq("rm_c4_dvalid", {31'b0, dvalid}, 32'd0);
    check_eq("rm_c4_req", {31'b0, mem_req}, 32'd0);
    check_eq("rm_c4_drdata", drdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
